fmul: RTL and testbench

FMUL -- requirements
Module: fmul

---
 rtl/fmul_pkg.sv | 22 ++
 rtl/fmul_unpack.sv | 38 +++
 rtl/fmul.sv | 108 ++++++++++
 tb/tb_fmul.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fmul_pkg.sv
// Shared binary32 field widths, constants and operand classification for the
// fmul multiplier and its operand unpacker.
package fmul_pkg;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned FRAC_W   = 23;
  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  localparam int unsigned SIG_W  = FRAC_W + 1;
  localparam int unsigned PROD_W = 2 * SIG_W;

  typedef enum logic [2:0] {
    ZERO,
    SUBNORMAL,
    NORMAL,
    INF,
    NAN
  } fclass_e;

endpackage

// File: rtl/fmul_unpack.sv
// Splits a binary32 operand into sign, unbiased effective exponent, 24-bit
// significand (explicit leading bit) and operand class.
module fmul_unpack
  import fmul_pkg::*;
(
  input  logic [31:0]       op_i,
  output logic              sign_o,
  output logic signed [9:0] exp_o,
  output logic [23:0]       sig_o,
  output fclass_e           cls_o
);

  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac_f;

  always_comb begin
    exp_f  = op_i[30:23];
    frac_f = op_i[22:0];
    sign_o = op_i[31];
    sig_o  = {(exp_f != '0), frac_f};

    // Subnormals share the minimum normal exponent but carry a leading 0.
    if (exp_f == '0) begin
      exp_o = -10'sd126;
    end else begin
      exp_o = $signed({2'b00, exp_f}) - 10'sd127;
    end

    if (exp_f == '0) begin
      cls_o = (frac_f == '0) ? ZERO : SUBNORMAL;
    end else if (exp_f == '1) begin
      cls_o = (frac_f == '0) ? INF : NAN;
    end else begin
      cls_o = NORMAL;
    end
  end

endmodule

// File: rtl/fmul.sv
// Single-cycle IEEE-754 binary32 multiplier, round-to-nearest-even with full
// subnormal support; the product is computed combinationally and registered.
module fmul
  import fmul_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] c_o
);

  logic              sa, sb;
  logic signed [9:0] ea, eb;
  logic [23:0]       siga, sigb;
  fclass_e           ca, cb;

  fmul_unpack u_unpack_a (
    .op_i   (a_i),
    .sign_o (sa),
    .exp_o  (ea),
    .sig_o  (siga),
    .cls_o  (ca)
  );

  fmul_unpack u_unpack_b (
    .op_i   (b_i),
    .sign_o (sb),
    .exp_o  (eb),
    .sig_o  (sigb),
    .cls_o  (cb)
  );

  logic [PROD_W-1:0]  prod;
  logic [5:0]         lz;
  logic [PROD_W-1:0]  norm;
  logic signed [10:0] exp_b;
  logic signed [10:0] unf;
  logic [6:0]         sh;
  logic [7:0]         base;
  logic [73:0]        wide;
  logic [73:0]        shifted;
  logic               lost;
  logic               guard, rbit, sticky, inc;
  logic [30:0]        rnd;
  logic               sign;
  logic [31:0]        c_d, c_q;

  always_comb begin
    prod = 48'(siga) * 48'(sigb);
    lz   = '0;
    for (int unsigned i = 0; i < PROD_W; i++) begin
      if (prod[i]) lz = 6'(47 - i);
    end
    norm = prod << lz;
    // Biased exponent of norm read as 1.f with the binary point below bit 47.
    exp_b = 11'(ea) + 11'(eb) + 11'(EXP_BIAS + 1) - 11'(lz);
    unf   = 11'sd1 - exp_b;

    if (exp_b < 11'sd1) begin
      sh   = (unf > 11'sd74) ? 7'd74 : unf[6:0];
      base = '0;
    end else begin
      sh   = '0;
      base = exp_b[7:0] - 8'd1;
    end

    wide    = {norm, 26'b0};
    shifted = wide >> sh;
    lost    = |(wide & ~({74{1'b1}} << sh));
    guard   = shifted[49];
    rbit    = shifted[48];
    sticky  = (|shifted[47:0]) | lost;
    inc     = guard & (rbit | sticky | shifted[50]);

    // Hidden bit adds onto base, so a rounding carry out of the fraction lands
    // in the exponent: renormalisation and subnormal-to-normal come for free.
    rnd = {base, 23'b0} + {7'b0, shifted[73:50]} + 31'(inc);
  end

  always_comb begin
    sign = sa ^ sb;
    c_d  = '0;
    if (ca == NAN || cb == NAN || (ca == INF && cb == ZERO) ||
        (ca == ZERO && cb == INF)) begin
      c_d = QNAN;
    end else if (ca == INF || cb == INF) begin
      c_d = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (ca == ZERO || cb == ZERO) begin
      c_d = {sign, 31'b0};
    end else if (exp_b >= $signed(11'(EXP_MAX))) begin
      c_d = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else begin
      c_d = {sign, rnd};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      c_q <= '0;
    end else begin
      c_q <= c_d;
    end
  end

  assign c_o = c_q;

endmodule

// File: tb/tb_fmul.sv
// Scoreboard bench for fmul: directed cases plus randomized operands checked
// against an integer-arithmetic model of binary32 multiplication.
module tb_fmul;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [31:0] c_o;

  logic [31:0] exp_q[$];
  string       name_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  fmul dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .a_i   (a_i),
    .b_i   (b_i),
    .c_o   (c_o)
  );

  always #5 clk = ~clk;

  // Exact product m*2^x, then rounded to the binary32 grid by integer division.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic   sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    longint ma, mb, m, q, rem, half;
    int     xa, xb, x, p, e, qe, d, biased;
    sgn    = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    a_zero = (a[30:0] == 0);
    b_zero = (b[30:0] == 0);
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) return 32'h7FC0_0000;
    if (a_inf || b_inf) return {sgn, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {sgn, 31'h0};
    ma = longint'({(a[30:23] != 0), a[22:0]});
    mb = longint'({(b[30:23] != 0), b[22:0]});
    xa = ((a[30:23] == 0) ? 1 : int'(a[30:23])) - 150;
    xb = ((b[30:23] == 0) ? 1 : int'(b[30:23])) - 150;
    m  = ma * mb;
    x  = xa + xb;
    p  = 0;
    for (int i = 0; i < 63; i++) if (m[i]) p = i + 1;
    e  = p - 1 + x;
    qe = ((e < -126) ? -126 : e) - 23;
    if (x >= qe) begin
      q = m << (x - qe);
    end else begin
      d = qe - x;
      if (d > 62) begin
        q = 0;
      end else begin
        q    = m >> d;
        rem  = m - (q << d);
        half = 64'sd1 << (d - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
      end
    end
    if (q == (64'sd1 << 24)) begin
      q  = q >> 1;
      qe = qe + 1;
    end
    if (q < (64'sd1 << 23)) return {sgn, 8'h00, q[22:0]};
    biased = qe + 150;
    if (biased >= 255) return {sgn, 8'hFF, 23'h0};
    return {sgn, biased[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0:       r[30:0]  = '0;
      1:       r[30:23] = 8'h00;
      2:       begin r[30:23] = 8'hFF; r[22:0] = '0; end
      3:       begin r[30:23] = 8'hFF; r[22] = 1'b1; end
      4:       r[30:23] = 8'(240 + $urandom_range(0, 14));
      5:       r[30:23] = 8'($urandom_range(1, 20));
      6:       r[30:23] = 8'($urandom_range(100, 150));
      default: ;
    endcase
    return r;
  endfunction

  task automatic issue(input logic r, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input string nm);
    @(negedge clk);
    rst_i = r;
    a_i   = a;
    b_i   = b;
    exp_q.push_back(expv);
    name_q.push_back(nm);
  endtask

  initial begin : monitor
    logic [31:0] expv;
    string       nm;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        #1;
        expv = exp_q.pop_front();
        nm   = name_q.pop_front();
        n_tests++;
        if (c_o !== expv) begin
          n_fail++;
          $display("FAIL %s: c_o=%h expected=%h", nm, c_o, expv);
        end
      end
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    string       nm;
  } dcase_t;

  dcase_t dir[] = '{
    '{32'h3F800000, 32'h3F800000, 32'h3F800000, "one_x_one"},
    '{32'h3F800000, 32'h40000000, 32'h40000000, "one_x_two"},
    '{32'h3FC00000, 32'h40000000, 32'h40400000, "1p5_x_two"},
    '{32'hBF800000, 32'h40000000, 32'hC0000000, "neg_sign"},
    '{32'h00000000, 32'h40000000, 32'h00000000, "pos_zero"},
    '{32'h80000000, 32'h40000000, 32'h80000000, "neg_zero"},
    '{32'h7F800000, 32'h00000000, 32'h7FC00000, "inf_x_zero"},
    '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, "overflow"},
    '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_in"},
    '{32'h3F800001, 32'h3F800001, 32'h3F800002, "round_ulp"},
    '{32'h00800000, 32'h3F000000, 32'h00400000, "to_subnormal"},
    '{32'h00000001, 32'h3F000000, 32'h00000000, "tie_even_zero"},
    '{32'h007FFFFF, 32'h3F800001, 32'h00800000, "sub_to_norm"},
    '{32'h7F800000, 32'hC0000000, 32'hFF800000, "inf_x_neg"},
    '{32'h80000000, 32'h7F800000, 32'h7FC00000, "nzero_x_inf"}
  };

  initial begin : stim
    logic [31:0] ra, rb;
    logic        rr;
    issue(1'b1, 32'h0, 32'h0, 32'h0, "reset0");
    issue(1'b1, 32'h3F800000, 32'h3F800000, 32'h0, "reset_hold");
    foreach (dir[i]) issue(1'b0, dir[i].a, dir[i].b, dir[i].c, dir[i].nm);
    issue(1'b1, 32'h3FC00000, 32'h40000000, 32'h0, "rst_mid");
    issue(1'b0, 32'h3FC00000, 32'h40000000, 32'h40400000, "rst_release");
    for (int n = 0; n < 3000; n++) begin
      ra = rand_op();
      rb = rand_op();
      rr = ($urandom_range(0, 49) == 0);
      issue(rr, ra, rb, rr ? 32'h0 : ref_mul(ra, rb), $sformatf("rnd %h*%h rst=%0b", ra, rb, rr));
    end
    @(posedge clk);
    #2;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: tests=%0d expected completion", n_tests);
    $fatal(1, "timeout");
  end

endmodule
